// File: rtl/debug_halt_ctrl_pkg.sv
// Shared types and defaults for the core-side debug halt/step controller.
package DebugStruct;
  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } DebugHaltState;

  localparam int DEBUG_STEP_TIMEOUT_DEF = 1024;
endpackage

// File: rtl/debug_edge_detect.sv
// Rising-edge pulse generator with a single flop of history.
module debug_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);
  logic q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= 1'b0;
    else       q <= din;

  assign rise = din & ~q;
endmodule

// File: rtl/debug_halt_ctrl.sv
// Halt/step FSM: drives the pipeline-wide stall and exports step/halt status.
module debug_halt_ctrl
  import DebugStruct::*;
#(
  parameter int STEP_TIMEOUT = DEBUG_STEP_TIMEOUT_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             debug_flag,
  input  logic             debug_step,
  input  logic             commit_valid,
  output logic             cpu_stall,
  output logic             halted,
  output logic             stepping,
  output logic             step_done,
  output logic             step_timeout,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] halt_cycles,
  output DebugHaltState    state
);
  localparam int TW = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(STEP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic          step_rise, commit;
  logic [TW-1:0] timer, timer_nxt;
  DebugHaltState state_nxt;
  logic          tmo_nxt, done_nxt, cnt_clr, cnt_inc, hc_clr;

  debug_edge_detect u_step_edge (
    .clk  (clk),
    .rstn (rstn),
    .din  (debug_step),
    .rise (step_rise)
  );

  assign commit   = commit_valid & ~cpu_stall;
  assign halted   = (state != RUN);
  assign stepping = (state == STEP);

  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    tmo_nxt   = step_timeout;
    done_nxt  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    hc_clr    = 1'b0;
    if (!debug_flag) begin
      state_nxt = RUN;
      tmo_nxt   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A step edge coinciding with the halt request is dropped.
          state_nxt = HALT;
          cnt_clr   = 1'b1;
          hc_clr    = 1'b1;
        end
        HALT: if (step_rise) begin
          state_nxt = STEP;
          tmo_nxt   = 1'b0;
        end
        STEP: begin
          if (commit) begin
            state_nxt = HALT;
            cnt_inc   = 1'b1;
            done_nxt  = 1'b1;
          end else if (timer == TMO_LAST) begin
            state_nxt = HALT;
            tmo_nxt   = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: state_nxt = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      cpu_stall    <= 1'b0;
      step_done    <= 1'b0;
      step_timeout <= 1'b0;
      step_count   <= '0;
      halt_cycles  <= '0;
      timer        <= '0;
    end else begin
      state        <= state_nxt;
      // Stall is asserted exactly when the next state is HALT, so the cycle
      // after a step's commit edge is already frozen.
      cpu_stall    <= (state_nxt == HALT);
      step_done    <= done_nxt;
      step_timeout <= tmo_nxt;
      timer        <= timer_nxt;
      if (cnt_clr)                            step_count <= '0;
      else if (cnt_inc && step_count != CNT_MAX) step_count <= step_count + 1'b1;
      if (hc_clr)                                  halt_cycles <= '0;
      else if (state != RUN && halt_cycles != CNT_MAX) halt_cycles <= halt_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Directed bench for debug_halt_ctrl with a cycle-level reference model.
module tb_debug_halt_ctrl;
  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 0, rstn = 0;
  logic debug_flag = 0, debug_step = 0, commit_valid = 0;
  logic cpu_stall, halted, stepping, step_done, step_timeout;
  logic [CW-1:0] step_count, halt_cycles;
  logic [1:0] state;

  debug_halt_ctrl #(.STEP_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .debug_flag(debug_flag), .debug_step(debug_step),
    .commit_valid(commit_valid), .cpu_stall(cpu_stall), .halted(halted),
    .stepping(stepping), .step_done(step_done), .step_timeout(step_timeout),
    .step_count(step_count), .halt_cycles(halt_cycles), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int retired = 0, dones = 0, step_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0=running, 1=frozen, 2=one-shot step window.
  int  m_mode, m_steps, m_hc, m_age;
  bit  m_frozen, m_done, m_tmo, m_btn;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_steps = 0; m_hc = 0; m_age = 0;
      m_frozen = 0; m_done = 0; m_tmo = 0; m_btn = 0;
    end else begin
      bit pressed, retire;
      pressed = debug_step && !m_btn;
      m_btn   = debug_step;
      retire  = commit_valid && !m_frozen;
      m_done  = 0;
      if (m_mode != 0 && m_hc < MAXC) m_hc++;
      if (!debug_flag) begin
        m_mode = 0; m_tmo = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_steps = 0; m_hc = 0;
      end else if (m_mode == 1) begin
        if (pressed) begin m_mode = 2; m_age = 0; m_tmo = 0; end
      end else begin
        m_age++;
        if (retire) begin
          m_mode = 1; m_done = 1;
          if (m_steps < MAXC) m_steps++;
        end else if (m_age >= TMO) begin
          m_mode = 1; m_tmo = 1;
        end
      end
      m_frozen = (m_mode == 1);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if (state !== 2'(m_mode) || cpu_stall !== m_frozen || halted !== (m_mode != 0) ||
        stepping !== (m_mode == 2) || step_done !== m_done || step_timeout !== m_tmo ||
        step_count !== CW'(m_steps) || halt_cycles !== CW'(m_hc)) begin
      errors++;
      $display("FAIL model_cmp t=%0t: dut st=%0d stall=%0b done=%0b tmo=%0b sc=%0d hc=%0d | exp st=%0d stall=%0b done=%0b tmo=%0b sc=%0d hc=%0d",
               $time, state, cpu_stall, step_done, step_timeout, step_count, halt_cycles,
               m_mode, m_frozen, m_done, m_tmo, m_steps, m_hc);
    end
    if (step_done) dones++;
    if (stepping) step_cyc++;
  end

  always @(posedge clk) if (rstn && commit_valid && !cpu_stall) retired++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, d0, s0;
    tick(3);
    rstn = 1;
    tick(1);
    chk("reset_state", state, 0);
    chk("reset_stall", cpu_stall, 0);
    chk("reset_count", step_count, 0);

    // Run until cycle 10 with instructions flowing, then request halt.
    commit_valid = 1;
    tick(6);
    debug_flag = 1;
    r0 = retired;
    tick(1);
    chk("halt_state", state, 1);
    chk("halt_stall", cpu_stall, 1);
    tick(5);
    chk("halt_latency_commits", retired - r0, 1);
    chk("halt_count0", step_count, 0);

    // Single step, button held for 50 cycles.
    r0 = retired; d0 = dones;
    debug_step = 1;
    tick(1);
    chk("step_enter", state, 2);
    chk("step_unstall", cpu_stall, 0);
    tick(1);
    chk("step_rehalt", state, 1);
    chk("step_done_pulse", step_done, 1);
    tick(50);
    chk("hold_one_commit", retired - r0, 1);
    chk("hold_one_done", dones - d0, 1);
    chk("hold_count1", step_count, 1);
    debug_step = 0; tick(2);
    debug_step = 1; tick(3);
    debug_step = 0; tick(2);
    chk("second_press", step_count, 2);

    // Step window expires with nothing to commit.
    commit_valid = 0;
    s0 = step_cyc;
    debug_step = 1; tick(1);
    debug_step = 0; tick(12);
    chk("timeout_window", step_cyc - s0, TMO);
    chk("timeout_flag", step_timeout, 1);
    chk("timeout_count", step_count, 2);
    chk("timeout_state", state, 1);
    chk("hc_saturated", halt_cycles, MAXC);
    debug_step = 1; tick(1);
    chk("timeout_clear", step_timeout, 0);
    debug_step = 0;

    // Drop the halt request mid-step.
    tick(2);
    debug_flag = 0;
    tick(1);
    chk("drop_state", state, 0);
    chk("drop_stall", cpu_stall, 0);
    debug_flag = 1;
    tick(1);
    chk("rehalt_count", step_count, 0);
    chk("rehalt_hc0", halt_cycles, 0);
    tick(1);
    chk("rehalt_hc1", halt_cycles, 1);

    // Saturation of the step counter.
    commit_valid = 1;
    repeat (20) begin
      debug_step = 1; tick(1);
      debug_step = 0; tick(2);
    end
    chk("count_saturate", step_count, MAXC);

    // Halt request and step edge in the same cycle: step is dropped.
    debug_flag = 0; tick(2);
    debug_flag = 1; debug_step = 1;
    tick(2);
    chk("same_cycle_step_dropped", state, 1);
    debug_step = 0; tick(1);

    // Asynchronous reset mid-step.
    commit_valid = 0;
    debug_step = 1; tick(1);
    debug_step = 0; tick(1);
    chk("pre_reset_stepping", stepping, 1);
    @(negedge clk); #2;
    rstn = 0;
    #1;
    chk("areset_state", state, 0);
    chk("areset_stall", cpu_stall, 0);
    chk("areset_hc", halt_cycles, 0);
    chk("areset_tmo", step_timeout, 0);
    tick(2);
    rstn = 1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
